// File: rtl/drm18k_arb_pkg.sv
// Shared types and helpers for the DRM18K port arbiter.
package drm18k_arb_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

  localparam int STALL_W = 16;

  // Saturating increment so a long stall never wraps back to a small count.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (v == {STALL_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/drm18k_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last winner so a tie
// always goes to the other requester.
module drm18k_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_last_gnt;

  // Grant decision: single requester wins outright, a tie goes away from r_last_gnt.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = r_last_gnt;
        o_gnt1 = ~r_last_gnt;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end else begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
    end
  end

  // Pointer resets to 1 so rq0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (o_gnt0) begin
      r_last_gnt <= 1'b0;
    end else if (o_gnt1) begin
      r_last_gnt <= 1'b1;
    end else begin
      r_last_gnt <= r_last_gnt;
    end
  end

endmodule

// File: rtl/drm18k_port_arbiter.sv
// Shares one DRM18K port between two requesters with a post-reset/on-demand
// clear sweep. Optional stall statistics are built when DRM_ARB_STATS_EN is defined.
module drm18k_port_arbiter
  import drm18k_arb_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 18,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clr_req,
  output logic               busy,
  input  logic               rq0_valid,
  output logic               rq0_ready,
  input  logic               rq0_we,
  input  logic [ADDR_W-1:0]  rq0_addr,
  input  logic [DATA_W-1:0]  rq0_wdata,
  input  logic               rq1_valid,
  output logic               rq1_ready,
  input  logic               rq1_we,
  input  logic [ADDR_W-1:0]  rq1_addr,
  input  logic [DATA_W-1:0]  rq1_wdata,
  output logic               rs0_valid,
  output logic [DATA_W-1:0]  rs0_rdata,
  output logic               rs1_valid,
  output logic [DATA_W-1:0]  rs1_rdata,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_din,
  output logic               ram_we,
  output logic               ram_ce,
  input  logic [DATA_W-1:0]  ram_q,
  output logic [STALL_W-1:0] stall_cnt0,
  output logic [STALL_W-1:0] stall_cnt1
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clr_last;
  rd_tag_t           r_tag [RD_LAT];
  rd_tag_t           w_push;
  rd_tag_t           w_tag_out;
  logic              w_tag_any;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_ram_ce;
  logic              w_ram_we;

  assign w_clr_last = (r_clr_cnt == {ADDR_W{1'b1}});

  drm18k_rr_arb2 u_arb (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (r_state == RUN),
    .i_req0  (rq0_valid),
    .i_req1  (rq1_valid),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  assign rq0_ready = w_gnt0;
  assign rq1_ready = w_gnt1;
  assign busy      = (r_state != RUN);

  // Next-state: DRAIN waits for every in-flight read tag before the sweep starts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   w_state_nxt = w_clr_last ? RUN : CLEAR;
      RUN:     w_state_nxt = clr_req ? DRAIN : RUN;
      DRAIN:   w_state_nxt = w_tag_any ? DRAIN : CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear address advances only while sweeping; DRAIN rearms it at 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_clr_cnt <= {ADDR_W{1'b0}};
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else if (r_state == DRAIN) begin
      r_clr_cnt <= {ADDR_W{1'b0}};
    end else begin
      r_clr_cnt <= r_clr_cnt;
    end
  end

  // RAM port mux: clear sweep, granted requester, or idle.
  always_comb begin
    w_ram_ce = 1'b0;
    w_ram_we = 1'b0;
    ram_addr = r_clr_cnt;
    ram_din  = CLEAR_VAL;
    case (r_state)
      CLEAR: begin
        w_ram_ce = 1'b1;
        w_ram_we = 1'b1;
      end
      RUN: begin
        if (w_gnt0) begin
          w_ram_ce = 1'b1;
          w_ram_we = rq0_we;
          ram_addr = rq0_addr;
          ram_din  = rq0_wdata;
        end else if (w_gnt1) begin
          w_ram_ce = 1'b1;
          w_ram_we = rq1_we;
          ram_addr = rq1_addr;
          ram_din  = rq1_wdata;
        end else begin
          w_ram_ce = 1'b0;
          w_ram_we = 1'b0;
        end
      end
      default: begin
        w_ram_ce = 1'b0;
        w_ram_we = 1'b0;
      end
    endcase
  end

  assign ram_ce = w_ram_ce & RST_N;
  assign ram_we = w_ram_we & RST_N;

  assign w_push.vld = (w_gnt0 & ~rq0_we) | (w_gnt1 & ~rq1_we);
  assign w_push.id  = w_gnt1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_push;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_comb begin
    w_tag_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_tag_any = w_tag_any | r_tag[i].vld;
    end
  end

  assign w_tag_out = r_tag[RD_LAT-1];
  assign rs0_valid = w_tag_out.vld & ~w_tag_out.id;
  assign rs1_valid = w_tag_out.vld &  w_tag_out.id;
  assign rs0_rdata = ram_q;
  assign rs1_rdata = ram_q;

`ifdef DRM_ARB_STATS_EN
  logic [STALL_W-1:0] r_stall0;
  logic [STALL_W-1:0] r_stall1;

  // Stall counters run in every state and only reset clears them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall0 <= {STALL_W{1'b0}};
      r_stall1 <= {STALL_W{1'b0}};
    end else begin
      r_stall0 <= (rq0_valid && !rq0_ready) ? sat_inc(r_stall0) : r_stall0;
      r_stall1 <= (rq1_valid && !rq1_ready) ? sat_inc(r_stall1) : r_stall1;
    end
  end

  assign stall_cnt0 = r_stall0;
  assign stall_cnt1 = r_stall1;
`else
  assign stall_cnt0 = {STALL_W{1'b0}};
  assign stall_cnt1 = {STALL_W{1'b0}};
`endif

endmodule

// File: doc/drm18k_port_arbiter.md
# drm18k_port_arbiter

Shares one DRM18K block-RAM port between two requesters (for example a MAC RX writer and a descriptor reader) using round-robin arbitration at one access per cycle. Read responses are routed back to the issuing requester and aligned to the RAM read latency. A sequenced clear engine writes `CLEAR_VAL` to every word after reset and on request, so the RAM contents are always known. The block sits between client logic and one port of `GTP_DRM18K_WRAPPER` (DA/ADA/WEA/CEA/QA side).

## Interface
Parameters:
- `ADDR_W`, 10: word address width; the clear sweep covers 2^ADDR_W words.
- `DATA_W`, 18: data width; must match the DRM18K port width.
- `RD_LAT`, 1: RAM read latency in cycles. Use 1 for OUTPUT_REG=0 and 2 for OUTPUT_REG=1; no other values are legal.
- `CLEAR_VAL`, 0: word written during a clear.

Ports:
- `CLK`  in  1  single clock for all logic and the RAM port.
- `RST_N`  in  1  asynchronous, active-low reset.
- `clr_req`  in  1  one-cycle pulse that requests a full RAM clear.
- `busy`  out  1  high while in DRAIN or CLEAR.
- `rqN_valid`, `rqN_ready`  in/out  1  request handshake, with N = 0 or 1.
- `rqN_we`  in  1  1 = write, 0 = read.
- `rqN_addr`  in  ADDR_W  request address.
- `rqN_wdata`  in  DATA_W  write data.
- `rsN_valid`  out  1  read response strobe.
- `rsN_rdata`  out  DATA_W  read response data.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_din`  out  DATA_W  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_ce`  out  1  RAM clock enable.
- `ram_q`  in  DATA_W  RAM read data.
- `stall_cnt0`, `stall_cnt1`  out  16  stall statistics (see Configuration).

## Operation
States: CLEAR, RUN, DRAIN. The reset state is CLEAR.

CLEAR:
- `rq0_ready` and `rq1_ready` are 0.
- `ram_ce=1`, `ram_we=1`, `ram_din=CLEAR_VAL`, `ram_addr=clr_cnt`.
- `clr_cnt` runs from 0 to 2^ADDR_W-1 and then wraps to 0.
- The state moves to RUN on the edge that writes the last address.
- `clr_req` is ignored in CLEAR.

RUN:
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester other than `last_gnt` is granted.
- `rqN_ready` is high for the granted requester only. Ready depends combinationally on both valid inputs.
- On grant:
  - `ram_ce=1`, `ram_we=rqN_we`, `ram_addr=rqN_addr`, `ram_din=rqN_wdata`.
  - `last_gnt` is set to N.
- No grant: `ram_ce=0`, `ram_we=0`.
- A read grant pushes a tag {valid, id} into an RD_LAT-deep shift register. A write grant pushes no tag.
- `clr_req` in RUN moves the state to DRAIN on the next edge. A grant in the same cycle as `clr_req` still completes.

DRAIN:
- No grants.
- The state moves to CLEAR, with `clr_cnt=0`, once the tag pipeline holds no valid entry.

Responses:
- When the tag output is valid, `rs[id]_valid=1` and `rs[id]_rdata=ram_q`. The other `rsN_valid` is 0.
- `rsN_rdata` is a pass-through of `ram_q` and is don't-care when its `rsN_valid` is 0.

Requester rule: while `rqN_valid=1` and `rqN_ready=0`, `rqN_we`, `rqN_addr` and `rqN_wdata` must stay stable. Dropping `rqN_valid` before the grant is illegal.

## Timing
- Reset values:
  - state=CLEAR, `clr_cnt=0`, `last_gnt=1` (rq0 wins the first tie).
  - Tag pipeline empty.
  - `busy=1`, `rsN_valid=0`, `rqN_ready=0`, stall counters 0.
  - `ram_ce` and `ram_we` are forced to 0 while `RST_N=0`.
- The first clear write occurs on the first edge after `RST_N` releases. A clear lasts 2^ADDR_W cycles.
- The write is committed at the handshake edge (cycle n).
- Read handshake in cycle n: `rsN_valid` is high in cycle n+RD_LAT for exactly one cycle.
- Throughput is one access per cycle across both requesters. When both are continuously valid, grants alternate 0,1,0,1.
- Read-after-write to the same address in consecutive grants returns the new data. This relies on the RAM being in NORMAL_WRITE mode with no access in the same cycle.
- A reset mid-operation aborts everything: outstanding tags are dropped and the clear restarts from address 0.

## Configuration
- `DRM_ARB_STATS_EN` defined: `stall_cntN` increments by 1 on each cycle where `rqN_valid=1` and `rqN_ready=0`, in any state. The counter saturates at 16'hFFFF and is cleared only by reset.
- `DRM_ARB_STATS_EN` undefined: `stall_cnt0` and `stall_cnt1` are tied to 0 and no counter flops are present. The ports exist in both builds.

## Structure
- Package `drm18k_arb_pkg`:
  - state enum {CLEAR, RUN, DRAIN};
  - tag struct {logic vld; logic id};
  - `STALL_W=16` constant.
- One sub-module: `drm18k_rr_arb2`, a combinational 2-way round-robin grant with a registered `last_gnt` pointer.
- The tag shift register, FSM and clear counter live in the top module.

## Test plan
- Reset release with ADDR_W=4: 16 cycles of `ram_we=1`, addresses 0..15, `din=0`, `busy=1`; then `busy=0`. Reads of every address return 0.
- rq0 writes 0x155 to addr 3, then rq1 reads addr 3: `rs1_valid` is high RD_LAT cycles after the read handshake with `rdata=0x155`, and `rs0_valid` stays 0.
- Both requesters hold valid reads for 6 cycles: grants go 0,1,0,1,0,1. Responses come back in the same order, each with the correct id.
- `clr_req` pulsed while 2 reads are outstanding with RD_LAT=2: both responses are delivered, DRAIN ends, then the CLEAR sweep runs and `rqN_ready` stays 0 throughout.
- `RST_N` asserted during CLEAR at `clr_cnt=7`: after release the sweep restarts at address 0, and `rsN_valid=0` throughout.
- With `DRM_ARB_STATS_EN`: rq1 is held valid and stalled for 5 cycles, giving `stall_cnt1=5`. A forced saturation holds the value at 16'hFFFF. Without the macro, both counters read 0.
